// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the parametrised audio blocks: sequencer state
// encoding and a constant-evaluable clog2.
package tone_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// AVR-side bus of the tone sequencer: note-table writes, playback control
// and status/speaker outputs.
interface tone_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned HALF_W = 20,
  parameter int unsigned DUR_W  = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [HALF_W-1:0] wr_half;
  logic [DUR_W-1:0]  wr_dur;
  logic [ADDR_W-1:0] last_addr;
  logic              loop;
  logic              start;
  logic              stop;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              done;
  logic              speaker;

  modport master (
    output wr_en, wr_addr, wr_half, wr_dur, last_addr, loop, start, stop,
    input  busy, note_idx, done, speaker
  );

  modport slave (
    input  wr_en, wr_addr, wr_half, wr_dur, last_addr, loop, start, stop,
    output busy, note_idx, done, speaker
  );
endinterface

// File: rtl/tone_sequencer_tick_prescaler.sv
// Divide-by-DIV timebase: counts DIV-1 down to 0 while enabled and emits a
// one-cycle tick on the zero count; clr reloads DIV-1.
module tone_sequencer_tick_prescaler
  import tone_sequencer_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned CW = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/tone_sequencer.sv
// Multi-note speaker driver: plays note-table entries 0..last_addr as a
// square wave with rests, skip entries, one-shot or looped playback.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned HALF_W  = 20,
  parameter int unsigned DUR_W   = 12,
  parameter int unsigned DEPTH   = 16
) (
  input logic             clk,
  input logic             rst,
  tone_sequencer_if.slave bus
);
  localparam int unsigned ADDR_W   = clog2(DEPTH);
  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;

  logic [HALF_W-1:0] half_mem [DEPTH];
  logic [DUR_W-1:0]  dur_mem  [DEPTH];

  seq_state_e        state_q;
  logic [ADDR_W-1:0] idx_q, last_q;
  logic [HALF_W-1:0] rd_half_q, half_q, hc_q;
  logic [DUR_W-1:0]  rd_dur_q, dur_q;
  logic              speaker_q, busy_q, done_q;

  logic [ADDR_W-1:0] adv_idx;
  logic              adv_load, note_end, tick;

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      half_mem[bus.wr_addr] <= bus.wr_half;
      dur_mem[bus.wr_addr]  <= bus.wr_dur;
    end
  end

  tone_sequencer_tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ST_LOAD),
    .en_i   (state_q == ST_PLAY),
    .tick_o (tick)
  );

  // A note ends either on a skip entry in LOAD or on its last duration tick.
  always_comb begin
    adv_load = 1'b1;
    adv_idx  = '0;
    if (idx_q < last_q) begin
      adv_idx = idx_q + ADDR_W'(1);
    end else if (!bus.loop) begin
      adv_load = 1'b0;
    end
    note_end = ((state_q == ST_LOAD) && (rd_dur_q == '0)) ||
               ((state_q == ST_PLAY) && tick && (dur_q == DUR_W'(1)));
  end

  // Table read is registered here: the entry is fetched on the edge that
  // enters LOAD, so the data is valid throughout the LOAD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      rd_half_q <= '0;
      rd_dur_q  <= '0;
      half_q    <= '0;
      dur_q     <= '0;
      hc_q      <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        speaker_q <= 1'b0;
      end else if (bus.start) begin
        state_q   <= ST_LOAD;
        busy_q    <= 1'b1;
        idx_q     <= '0;
        last_q    <= bus.last_addr;
        rd_half_q <= half_mem[ADDR_W'(0)];
        rd_dur_q  <= dur_mem[ADDR_W'(0)];
        speaker_q <= 1'b0;
      end else if (note_end) begin
        speaker_q <= 1'b0;
        if (adv_load) begin
          state_q   <= ST_LOAD;
          idx_q     <= adv_idx;
          rd_half_q <= half_mem[adv_idx];
          rd_dur_q  <= dur_mem[adv_idx];
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else if (state_q == ST_LOAD) begin
        state_q   <= ST_PLAY;
        half_q    <= rd_half_q;
        dur_q     <= rd_dur_q;
        hc_q      <= '0;
        speaker_q <= 1'b0;
      end else if (state_q == ST_PLAY) begin
        if (tick) begin
          dur_q <= dur_q - DUR_W'(1);
        end
        if (half_q != '0) begin
          if (hc_q == half_q - HALF_W'(1)) begin
            hc_q      <= '0;
            speaker_q <= ~speaker_q;
          end else begin
            hc_q <= hc_q + HALF_W'(1);
          end
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.note_idx = idx_q;
  assign bus.done     = done_q;
  assign bus.speaker  = speaker_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at 10 clk per duration tick, DEPTH=4.
module tb_tone_sequencer;

  typedef struct {
    int         c;
    bit         start;
    bit         stop;
    bit         loop;
    bit         busy;
    bit         done;
    bit         spk;
    bit         ck_idx;
    logic [1:0] idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  tone_sequencer_if #(.ADDR_W(2), .HALF_W(8), .DUR_W(8)) bus ();

  tone_sequencer #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .HALF_W  (8),
    .DUR_W   (8),
    .DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_entry(input int a, input int h, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(a);
    bus.wr_half = 8'(h);
    bus.wr_dur  = 8'(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  function automatic vec_t mk(int c, bit st, bit sp, bit lp, bit b, bit d, bit s,
                              bit ci, int idx);
    vec_t v;
    v.c = c; v.start = st; v.stop = sp; v.loop = lp;
    v.busy = b; v.done = d; v.spk = s; v.ck_idx = ci; v.idx = 2'(idx);
    return v;
  endfunction

  // c counts observations after the start-sampling edge (c=0 is LOAD).
  task automatic run_vecs(input string tag);
    int c = -1;
    foreach (vq[i]) begin
      while (c < vq[i].c) begin
        step();
        c++;
      end
      chk($sformatf("%s c=%0d busy", tag, c), 32'(bus.busy), 32'(vq[i].busy));
      chk($sformatf("%s c=%0d done", tag, c), 32'(bus.done), 32'(vq[i].done));
      chk($sformatf("%s c=%0d speaker", tag, c), 32'(bus.speaker), 32'(vq[i].spk));
      if (vq[i].ck_idx) begin
        chk($sformatf("%s c=%0d note_idx", tag, c), 32'(bus.note_idx), 32'(vq[i].idx));
      end
      bus.start = vq[i].start;
      bus.stop  = vq[i].stop;
      bus.loop  = vq[i].loop;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_half = '0; bus.wr_dur = '0;
    bus.last_addr = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset speaker", 32'(bus.speaker), 0);
    chk("reset note_idx", 32'(bus.note_idx), 0);
    rst = 1'b0;
    step();

    // Single note: half=3, dur=2 -> 20 PLAY cycles toggling every 3.
    write_entry(0, 3, 2);
    bus.last_addr = 2'd0;
    bus.loop  = 1'b0;
    bus.start = 1'b1;
    chk("t1 busy before start edge", 32'(bus.busy), 0);
    step();
    bus.start = 1'b0;
    chk("t1 busy after start", 32'(bus.busy), 1);
    chk("t1 load speaker", 32'(bus.speaker), 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("t1 play k=%0d speaker", k), 32'(bus.speaker), 32'((k / 3) % 2));
    end
    chk("t1 busy last play", 32'(bus.busy), 1);
    step();
    chk("t1 done pulse", 32'(bus.done), 1);
    chk("t1 busy end", 32'(bus.busy), 0);
    chk("t1 speaker end", 32'(bus.speaker), 0);
    step();
    chk("t1 done cleared", 32'(bus.done), 0);

    // stop together with start during PLAY: stop wins, no restart.
    vq.delete();
    vq.push_back(mk(-1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk( 5, 1, 1, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk( 6, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk( 7, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 9, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("stopstart");

    // Three entries: tone, rest, skip.
    write_entry(0, 2, 1);
    write_entry(1, 0, 1);
    write_entry(2, 5, 0);
    bus.last_addr = 2'd2;

    vq.delete();
    vq.push_back(mk(-1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk( 1, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk( 3, 0, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk( 4, 0, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk( 5, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk( 7, 0, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(10, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(11, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(12, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(16, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(21, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(22, 0, 0, 0, 1, 0, 0, 1, 2));
    vq.push_back(mk(23, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(24, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("seq3");

    // Same table looped, then loop dropped during entry 1 of the third pass.
    vq.delete();
    vq.push_back(mk(-1, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk( 0, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(22, 0, 0, 1, 1, 0, 0, 1, 2));
    vq.push_back(mk(23, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(24, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(26, 0, 0, 1, 1, 0, 1, 1, 0));
    vq.push_back(mk(34, 0, 0, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(45, 0, 0, 1, 1, 0, 0, 1, 2));
    vq.push_back(mk(46, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(60, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(68, 0, 0, 0, 1, 0, 0, 1, 2));
    vq.push_back(mk(69, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(70, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vecs("loop");

    // start alone while busy: restart from entry 0 without done.
    vq.delete();
    vq.push_back(mk(-1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(14, 1, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(mk(15, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(17, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(18, 0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(mk(37, 0, 0, 0, 1, 0, 0, 1, 2));
    vq.push_back(mk(38, 0, 0, 0, 0, 1, 0, 0, 0));
    run_vecs("restart");

    // Rewrite entry 0 mid-note: current note keeps half=3, reload uses 7.
    write_entry(0, 3, 2);
    bus.last_addr = 2'd0;
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      int exp_s;
      step();
      if (c == 6) bus.wr_en = 1'b0;
      if (c <= 20)      exp_s = ((c - 1) / 3) % 2;
      else if (c == 21) exp_s = 0;
      else              exp_s = ((c - 22) / 7) % 2;
      chk($sformatf("rewrite c=%0d speaker", c), 32'(bus.speaker), 32'(exp_s));
      if (c == 5) begin
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_half = 8'd7; bus.wr_dur = 8'd2;
      end
    end
    bus.loop = 1'b0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("rewrite stop done", 32'(bus.done), 1);
    chk("rewrite stop busy", 32'(bus.busy), 0);
    step();

    // Asynchronous reset in the middle of entry 1.
    write_entry(0, 2, 1);
    write_entry(1, 2, 1);
    bus.last_addr = 2'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) step();
    chk("prerst speaker", 32'(bus.speaker), 1);
    chk("prerst note_idx", 32'(bus.note_idx), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst speaker", 32'(bus.speaker), 0);
    chk("async rst busy", 32'(bus.busy), 0);
    chk("async rst done", 32'(bus.done), 0);
    chk("async rst note_idx", 32'(bus.note_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    chk("post rst speaker", 32'(bus.speaker), 0);
    chk("post rst busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Parametrised multi-note speaker driver, successor to the fixed single-tone generator on the top level. Holds a programmable note table (half-period, duration per entry) written from the AVR side and plays entries 0..last_addr back on the speaker pin as a square wave, with rests, one-shot or looped playback, and start/stop control. Sits between the AVR interface/control logic and the speaker output.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 1000, duration tick rate (default 1 ms per tick)
HALF_W, 20, half-period count width in clk cycles (min tone about 24 Hz at 50 MHz)
DUR_W, 12, duration width in ticks
DEPTH, 16, note table entries (power of 2); ADDR_W = clog2(DEPTH) is a derived localparam

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write address
wr_half  in  HALF_W  half-period in clk cycles; 0 = rest
wr_dur  in  DUR_W  duration in ticks; 0 = skip entry
last_addr  in  ADDR_W  final entry of sequence, sampled on start
loop  in  1  replay from entry 0 after last_addr; sampled at sequence end
start  in  1  begin or restart playback (level ok, acted on when high)
stop  in  1  abort playback
busy  out  1  high in LOAD/PLAY
note_idx  out  ADDR_W  entry currently loaded
done  out  1  one-cycle pulse at end of non-looped sequence or on stop
speaker  out  1  square-wave output

Behaviour:
- Reset (async): state IDLE, speaker 0, busy 0, done 0, note_idx 0, all counters 0. Table contents undefined, not cleared.
- Table: synchronous write on wr_en, allowed in any state. Registered read, 1-cycle latency. A write to the playing entry takes effect the next time that entry is loaded.
- States: IDLE, LOAD, PLAY.
- IDLE: start=1 -> capture last_addr, note_idx=0, go to LOAD; busy rises the next cycle.
- LOAD: one cycle while the read completes, then latch half/dur and clear the half-counter and tick prescaler. If dur=0, advance immediately (see next-entry rule). Otherwise go to PLAY, speaker 0.
- PLAY: the half-counter increments each clk. At count=half-1 the counter clears and speaker toggles. If half=0, the speaker stays 0 (rest). The prescaler produces a tick every CLK_HZ/TICK_HZ cycles; each tick decrements the remaining duration. Reaching 0 applies the next-entry rule, and speaker is forced 0 in the same cycle.
- Next-entry rule: if note_idx<last_addr, increment note_idx and go to LOAD. Else if loop=1, note_idx=0 and LOAD. Else done=1 for one cycle, IDLE, busy=0.
- Start latency: start sampled at edge t gives LOAD at t+1 and PLAY at t+2. The first toggle comes half cycles after entering PLAY.
- stop=1 in LOAD/PLAY: next cycle IDLE, speaker 0, busy 0, done pulse. stop wins over start in the same cycle. stop in IDLE has no effect and no done.
- start=1 while busy (and stop=0): restart from entry 0 and recapture last_addr, without a done pulse.
- Tick prescaler wrap: CLK_HZ/TICK_HZ-1 down to 0, reloaded on every LOAD so each duration is exact to ±0 cycles.
- Total playback cycles per entry = 1 (LOAD) + dur*CLK_HZ/TICK_HZ.
- All-dur=0 sequence with loop=1: cycles through LOAD states indefinitely, speaker 0. This is legal.

Decomposition:
- Shared package/include: state encoding (IDLE/LOAD/PLAY) and a clog2 function. The same package serves other parametrised audio blocks.
- One natural sub-module: tick_prescaler (parametrised divide-by-N, sync clear input, one-cycle tick output), reusable for the tone timebase elsewhere.

Test Plan:
- Bench params CLK_HZ=1000, TICK_HZ=100 (10 clk/tick), DEPTH=4.
- Reset mid-PLAY -> speaker, busy, done, note_idx all 0 immediately (async). No toggle on the next clk until start.
- Entry0 half=3 dur=2, last_addr=0, loop=0, start pulse -> busy at t+1. Speaker toggles every 3 cycles for 20 PLAY cycles, then done pulse, busy=0, speaker 0.
- Entries 0..2 = (half 2, dur 1), (half 0, dur 1), (half 5, dur 0), last_addr=2 -> 10 cycles of toggling, 10 cycles of speaker 0, entry 2 skipped after its LOAD, done after 1+10+1+10+1 cycles.
- Same table with loop=1 -> note_idx sequence 0,1,2,0,1… and no done. Drop loop during entry 1 -> done after entry 2.
- stop and start asserted together during PLAY -> IDLE next cycle, done pulse, no restart. start alone while busy -> note_idx returns to 0, no done.
- wr_en to entry 0 during its PLAY with half=7 -> current note unchanged. On loop back, the toggle period becomes 7.
